// File: rtl/axi_read_arbiter.sv
// Read-channel arbiter for a 4-master AXI crossbar. It produces registered one-hot
// read grants, holds each grant from arbitration through the AR handshake and the
// whole R burst, and checks where RLAST falls against the captured burst length.
module axi_read_arbiter #(
  parameter int unsigned ARB_MODE  = 0,  // 0: round-robin, 1: fixed priority (master 0 highest)
  parameter int unsigned CNT_WIDTH = 9   // must hold ARLEN+1 = 256
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       s0_ARVALID,
  input  logic       s1_ARVALID,
  input  logic       s2_ARVALID,
  input  logic       s3_ARVALID,
  input  logic       s2m_ARVALID,
  input  logic       s2m_ARREADY,
  input  logic [7:0] s2m_ARLEN,
  input  logic       s2m_RVALID,
  input  logic       s2m_RREADY,
  input  logic       s2m_RLAST,
  output logic       s0_rgrnt,
  output logic       s1_rgrnt,
  output logic       s2_rgrnt,
  output logic       s3_rgrnt,
  output logic       rd_busy,
  output logic       rlast_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e               state_q, state_d;
  logic [3:0]           req;
  logic [3:0]           pick;
  logic [3:0]           grant_q, grant_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           idx;
  logic [1:0]           gidx;
  logic                 found;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0] beats_q, beats_d;
  logic                 err_q, err_d;

  assign req = {s3_ARVALID, s2_ARVALID, s1_ARVALID, s0_ARVALID};

  // Winner selection: scan in priority order and take the first requester.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = (ARB_MODE == 1) ? 2'(k) : ptr_q + 2'(k + 1);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
      end
    end
  end

  // Index of the current grant holder; becomes the round-robin pointer on release.
  always_comb begin
    gidx = '0;
    for (int k = 0; k < 4; k++) begin
      if (grant_q[k]) gidx = 2'(k);
    end
  end

  // Beat count after the current beat; sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Next-state logic: arbitrate in IDLE, wait for AR in ADDR, count R beats in DATA.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = pick;
          state_d = StAddr;
        end
      end
      StAddr: begin
        // Any R beat seen here precedes the AR handshake and is ignored.
        if (s2m_ARVALID && s2m_ARREADY) begin
          beats_d = CNT_WIDTH'(s2m_ARLEN) + CNT_WIDTH'(1);
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (s2m_RVALID && s2m_RREADY) begin
          cnt_d = cnt_inc;
          if (s2m_RLAST) begin
            err_d   = (cnt_inc != beats_q);
            grant_d = '0;
            ptr_d   = gidx;
            state_d = StIdle;
          end else begin
            err_d = (cnt_inc == beats_q);
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset drops the grants immediately, even mid-burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  assign s0_rgrnt  = grant_q[0];
  assign s1_rgrnt  = grant_q[1];
  assign s2_rgrnt  = grant_q[2];
  assign s3_rgrnt  = grant_q[3];
  assign rd_busy   = (state_q != StIdle);
  assign rlast_err = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: a round-robin and a fixed-priority instance share the
// same stimulus and are compared every cycle against a transaction-level model.
module tb_axi_read_arbiter;

  localparam int CntMax = 511;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req;
  logic       arv, arr, rv, rr, rl;
  logic [7:0] arlen;
  logic [3:0] g_rr, g_fx;
  logic       busy_rr, busy_fx, err_rr, err_fx;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ARB_MODE(0), .CNT_WIDTH(9)) dut_rr (
    .clk(clk), .rstn(rstn),
    .s0_ARVALID(req[0]), .s1_ARVALID(req[1]), .s2_ARVALID(req[2]), .s3_ARVALID(req[3]),
    .s2m_ARVALID(arv), .s2m_ARREADY(arr), .s2m_ARLEN(arlen),
    .s2m_RVALID(rv), .s2m_RREADY(rr), .s2m_RLAST(rl),
    .s0_rgrnt(g_rr[0]), .s1_rgrnt(g_rr[1]), .s2_rgrnt(g_rr[2]), .s3_rgrnt(g_rr[3]),
    .rd_busy(busy_rr), .rlast_err(err_rr)
  );

  axi_read_arbiter #(.ARB_MODE(1), .CNT_WIDTH(9)) dut_fx (
    .clk(clk), .rstn(rstn),
    .s0_ARVALID(req[0]), .s1_ARVALID(req[1]), .s2_ARVALID(req[2]), .s3_ARVALID(req[3]),
    .s2m_ARVALID(arv), .s2m_ARREADY(arr), .s2m_ARLEN(arlen),
    .s2m_RVALID(rv), .s2m_RREADY(rr), .s2m_RLAST(rl),
    .s0_rgrnt(g_fx[0]), .s1_rgrnt(g_fx[1]), .s2_rgrnt(g_fx[2]), .s3_rgrnt(g_fx[3]),
    .rd_busy(busy_fx), .rlast_err(err_fx)
  );

  int checks   = 0;
  int failures = 0;

  // Model, index 0 = round-robin, 1 = fixed priority. Owner -1 means nobody holds the port.
  int m_own[2];
  int m_last[2];
  int m_beats[2];
  int m_seen[2];
  bit m_addr_done[2];
  bit m_err[2];

  // Scenario observation
  logic [3:0] prev_rr, prev_fx;
  bit         rec_order;
  int         order_q[$];
  int         fx_s1_wins, fx_s3_wins, err_pulses;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick_winner(input int m, input logic [3:0] r, input int last);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (m == 1) ? k : (last + 1 + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant(input int m);
    if (m_own[m] < 0) return 4'b0000;
    return 4'(1 << m_own[m]);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_own[m]       = -1;
      m_last[m]      = 3;
      m_beats[m]     = 0;
      m_seen[m]      = 0;
      m_addr_done[m] = 1'b0;
      m_err[m]       = 1'b0;
    end
  endtask

  // One clock edge of the transaction model, using the inputs held across the edge.
  task automatic model_edge();
    int w;
    bit e;
    for (int m = 0; m < 2; m++) begin
      e = 1'b0;
      if (m_own[m] < 0) begin
        w = pick_winner(m, req, m_last[m]);
        if (w >= 0) begin
          m_own[m]       = w;
          m_addr_done[m] = 1'b0;
        end
      end else if (!m_addr_done[m]) begin
        if (arv && arr) begin
          m_addr_done[m] = 1'b1;
          m_beats[m]     = int'(arlen) + 1;
          m_seen[m]      = 0;
        end
      end else if (rv && rr) begin
        if (m_seen[m] < CntMax) m_seen[m]++;
        if (rl) begin
          e         = (m_seen[m] != m_beats[m]);
          m_last[m] = m_own[m];
          m_own[m]  = -1;
        end else begin
          e = (m_seen[m] == m_beats[m]);
        end
      end
      m_err[m] = e;
    end
  endtask

  task automatic compare();
    check("rr_grant", g_rr, exp_grant(0));
    check("rr_busy", busy_rr, m_own[0] >= 0);
    check("rr_err", err_rr, m_err[0]);
    check("fx_grant", g_fx, exp_grant(1));
    check("fx_busy", busy_fx, m_own[1] >= 0);
    check("fx_err", err_fx, m_err[1]);
  endtask

  // Advance one clock, update the model, then sample #1 after the edge.
  task automatic step();
    @(posedge clk);
    if (rstn) model_edge();
    #1;
    compare();
    if (rec_order && g_rr != 4'b0 && prev_rr == 4'b0) begin
      for (int i = 0; i < 4; i++) if (g_rr[i]) order_q.push_back(i);
    end
    if (g_fx != 4'b0 && prev_fx == 4'b0) begin
      if (g_fx == 4'b0010) fx_s1_wins++;
      if (g_fx == 4'b1000) fx_s3_wins++;
    end
    if (err_rr) err_pulses++;
    prev_rr = g_rr;
    prev_fx = g_fx;
  endtask

  task automatic clear_inputs();
    req = 4'b0; arv = 1'b0; arr = 1'b0; arlen = 8'd0; rv = 1'b0; rr = 1'b0; rl = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    model_reset();
    #3;
    rstn    = 1'b1;
    prev_rr = 4'b0;
    prev_fx = 4'b0;
  endtask

  // Wait for a grant, do the AR handshake, then stream beats with RLAST on beat rlast_at.
  task automatic do_burst(input int len, input int rlast_at, input bit toggle);
    int w = 0;
    int n = 0;
    int guard = 0;
    while (m_own[0] < 0 && w < 20) begin
      step();
      w++;
    end
    if (m_own[0] < 0) check("grant_timeout", 32'd0, 32'd1);
    arv = 1'b1; arr = 1'b1; arlen = 8'(len);
    step();
    arv = 1'b0; arr = 1'b0;
    rr  = 1'b0;
    while (n < rlast_at && guard < 4 * rlast_at + 16) begin
      rv = 1'b1;
      rr = toggle ? ~rr : 1'b1;
      rl = rr && (n + 1 == rlast_at);
      step();
      if (rr) n++;
      guard++;
    end
    if (n < rlast_at) check("beat_timeout", n, rlast_at);
    rv = 1'b0; rr = 1'b0; rl = 1'b0;
  endtask

  initial begin
    rec_order  = 1'b0;
    fx_s1_wins = 0;
    fx_s3_wins = 0;
    err_pulses = 0;
    prev_rr    = 4'b0;
    prev_fx    = 4'b0;
    clear_inputs();
    rstn = 1'b0;
    model_reset();
    #12;
    check("reset_grant_rr", g_rr, 4'b0);
    check("reset_grant_fx", g_fx, 4'b0);
    check("reset_busy", busy_rr, 1'b0);
    check("reset_err", err_rr, 1'b0);
    rstn = 1'b1;

    // Single request from master 2, 4-beat burst
    req = 4'b0100;
    step();
    check("t1_s2_grant", g_rr, 4'b0100);
    req = 4'b0;
    err_pulses = 0;
    do_burst(3, 4, 1'b0);
    check("t1_release", g_rr, 4'b0);
    check("t1_no_err", err_pulses, 0);

    // Round-robin fairness with everyone requesting
    do_reset();
    req = 4'hF;
    rec_order = 1'b1;
    order_q.delete();
    for (int b = 0; b < 5; b++) begin
      do_burst(0, 1, 1'b0);
      check("t2_bubble", g_rr, 4'b0);
    end
    req = 4'b0;
    rec_order = 1'b0;
    check("t2_order_len", order_q.size(), 5);
    if (order_q.size() == 5) begin
      check("t2_order0", order_q[0], 0);
      check("t2_order1", order_q[1], 1);
      check("t2_order2", order_q[2], 2);
      check("t2_order3", order_q[3], 3);
      check("t2_order4", order_q[4], 0);
    end
    step();

    // Fixed priority: masters 1 and 3 contend
    fx_s1_wins = 0;
    fx_s3_wins = 0;
    req = 4'b1010;
    for (int b = 0; b < 4; b++) do_burst(1, 2, 1'b0);
    req = 4'b0;
    step();
    check("t3_fx_s1_wins", fx_s1_wins, 4);
    check("t3_fx_s3_wins", fx_s3_wins, 0);

    // Early RLAST: ARLEN=7, RLAST on beat 5
    err_pulses = 0;
    req = 4'b0001;
    step();
    req = 4'b0;
    do_burst(7, 5, 1'b0);
    check("t4_early_err", err_pulses, 1);
    check("t4_release", g_rr, 4'b0);
    step();

    // Missing RLAST: ARLEN=1, RLAST withheld until beat 3
    req = 4'b0010;
    step();
    req = 4'b0;
    do_burst(1, 3, 1'b0);
    check("t4_late_release", g_rr, 4'b0);
    step();

    // Maximum burst with RREADY toggling
    err_pulses = 0;
    req = 4'b1000;
    step();
    req = 4'b0;
    do_burst(255, 256, 1'b1);
    check("t5_no_err", err_pulses, 0);
    check("t5_release", g_rr, 4'b0);
    step();

    // Reset mid-DATA after beat 2 of 4
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0;
    arv = 1'b1; arr = 1'b1; arlen = 8'd3;
    step();
    arv = 1'b0; arr = 1'b0;
    rv = 1'b1; rr = 1'b1;
    step();
    step();
    rv = 1'b0; rr = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("t6_async_grant_rr", g_rr, 4'b0);
    check("t6_async_grant_fx", g_fx, 4'b0);
    check("t6_async_busy", busy_rr, 1'b0);
    model_reset();
    req = 4'b0010;
    #1;
    rstn = 1'b1;
    prev_rr = 4'b0;
    prev_fx = 4'b0;
    step();
    check("t6_s1_grant", g_rr, 4'b0010);
    req = 4'b0;
    do_burst(0, 1, 1'b0);

    // Randomized traffic on every input
    for (int c = 0; c < 1500; c++) begin
      req   = 4'($urandom_range(0, 15));
      arv   = 1'($urandom_range(0, 1));
      arr   = 1'($urandom_range(0, 1));
      arlen = 8'($urandom_range(0, 3));
      rv    = 1'($urandom_range(0, 1));
      rr    = 1'($urandom_range(0, 1));
      rl    = ($urandom_range(0, 3) == 0);
      step();
    end
    clear_inputs();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
